// File: rtl/calc_multiplier_pkg.sv
// Shared types and constants for the calculator multiplier.
package calc_pkg;

    localparam int CALC_WIDTH  = 32;
    localparam int MUL_LATENCY = CALC_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mul_state_t;

endpackage

// File: rtl/calc_multiplier_if.sv
// Operand/result handshake bundle between the calculator and the multiplier.
interface calc_multiplier_if #(
    parameter int WIDTH = calc_pkg::CALC_WIDTH
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 is_signed;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/calc_multiplier.sv
// Sequential shift-add multiplier with signed/unsigned operands.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for an operand pair; in_ready high once out of reset
// RUN   | one multiplier bit per cycle; counter runs WIDTH down to 0
// FIX   | one cycle; negate the magnitude product if signs differed
// DONE  | product presented with out_valid until out_ready
//
// Latency from accepting edge to out_valid is WIDTH+2 edges: WIDTH
// shift-add edges, the terminal-count edge leaving RUN, and the FIX edge.
module calc_multiplier
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic            clk,
    input  logic            reset_n,
    calc_multiplier_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);

    mul_state_t           state;
    mul_state_t           state_nxt;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic                 negate;
    logic                 rdy_q;
    logic                 accept;
    logic                 neg_a;
    logic                 neg_b;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1),
    // which still fits as an unsigned WIDTH-bit number.
    assign neg_a  = bus.is_signed && bus.a[WIDTH-1];
    assign neg_b  = bus.is_signed && bus.b[WIDTH-1];
    assign mag_a  = neg_a ? (~bus.a + WIDTH'(1)) : bus.a;
    assign mag_b  = neg_b ? (~bus.b + WIDTH'(1)) : bus.b;
    assign accept = bus.in_valid && bus.in_ready;

    // Holds in_ready low during reset until the first clock after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)            state_nxt = RUN;
            RUN:  if (cnt == '0)         state_nxt = FIX;
            FIX:                         state_nxt = DONE;
            DONE: if (bus.out_ready)     state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    // Handshake outputs; product is forced to zero outside DONE.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        bus.product   = '0;
        case (state)
            IDLE: begin
                bus.in_ready = rdy_q;
                bus.busy     = 1'b0;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                bus.product   = acc;
            end
            default: ;
        endcase
    end

    // Datapath: capture magnitudes, shift-add, then optional negation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            negate <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt    <= CW'(WIDTH);
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, mag_a};
                        mplier <= mag_b;
                        negate <= neg_a ^ neg_b;
                    end
                end
                RUN: begin
                    if (cnt != '0) begin
                        if (mplier[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt - CW'(1);
                    end
                end
                FIX: begin
                    if (negate) begin
                        acc <= -acc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_multiplier.sv
// Directed self-checking bench for calc_multiplier at WIDTH=32.
module tb_calc_multiplier;

    localparam int EXP_LAT = 34;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    calc_multiplier_if #(.WIDTH(32)) bus ();

    calc_multiplier #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", 64'(bus.in_ready), 64'd1);
    endtask

    task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_b, input logic ts);
        wait_ready();
        bus.in_valid  = 1'b1;
        bus.a         = ta;
        bus.b         = tb_b;
        bus.is_signed = ts;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.a         = $urandom;
        bus.b         = $urandom;
        bus.is_signed = ~ts;
        check("busy_after_accept", 64'(bus.busy), 64'd1);
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (bus.out_valid !== 1'b1 && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic do_op(input string name, input logic [31:0] ta, input logic [31:0] tb_b,
                         input logic ts, input logic [63:0] exp, input bit early);
        int e;
        bus.out_ready = early;
        start_op(ta, tb_b, ts);
        wait_done(e);
        check({name, "_latency"}, 64'(e), 64'(EXP_LAT));
        check({name, "_product"}, bus.product, exp);
        if (!early) begin
            @(posedge clk); #1;
            check({name, "_hold"}, 64'(bus.out_valid), 64'd1);
            bus.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({name, "_out_valid_drop"}, 64'(bus.out_valid), 64'd0);
        check({name, "_in_ready_back"}, 64'(bus.in_ready), 64'd1);
        check({name, "_product_zero"}, bus.product, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  e;
        bit  seen;

        vecs[0] = '{32'd6,          32'd7,          1'b0, 64'h0000_0000_0000_002A};
        vecs[1] = '{32'hFFFF_FFFD,  32'd5,          1'b1, 64'hFFFF_FFFF_FFFF_FFF1};
        vecs[2] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 64'hFFFF_FFFE_0000_0001};
        vecs[3] = '{32'h8000_0000,  32'h8000_0000,  1'b1, 64'h4000_0000_0000_0000};
        vecs[4] = '{32'd0,          32'h1234,       1'b0, 64'h0};
        vecs[5] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 64'h1};
        vecs[6] = '{32'h8000_0000,  32'd1,          1'b1, 64'hFFFF_FFFF_8000_0000};
        vecs[7] = '{32'h8000_0000,  32'd2,          1'b0, 64'h0000_0001_0000_0000};
        vecs[8] = '{32'd7,          32'hFFFF_FFFA,  1'b1, 64'hFFFF_FFFF_FFFF_FFD6};
        vecs[9] = '{32'h1234_5678,  32'h10,         1'b0, 64'h0000_0001_2345_6780};

        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.is_signed = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check("rst_in_ready",  64'(bus.in_ready),  64'd0);
        check("rst_busy",      64'(bus.busy),      64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_product",   bus.product,        64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready_held", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rel_in_ready_pre_edge", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        check("rel_in_ready_first_edge", 64'(bus.in_ready), 64'd1);

        for (int i = 0; i < 10; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, (i % 3) == 2);
        end

        // Backpressure with ignored in_valid pulses during RUN and DONE.
        bus.out_ready = 1'b0;
        start_op(32'd3, 32'd4, 1'b0);
        e = 0;
        while (bus.out_valid !== 1'b1 && e < 100) begin
            bus.in_valid = e[0];
            bus.a        = 32'(e + 100);
            bus.b        = 32'd9;
            @(posedge clk); #1;
            e++;
            check("bp_run_in_ready", 64'(bus.in_ready), 64'd0);
        end
        check("bp_latency", 64'(e), 64'(EXP_LAT));
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = 1'b1;
            bus.a        = 32'd99;
            @(posedge clk); #1;
            check("bp_product_stable", bus.product, 64'd12);
            check("bp_out_valid_held", 64'(bus.out_valid), 64'd1);
            check("bp_done_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
        check("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        check("bp_no_stray_accept", 64'(bus.busy), 64'd0);

        // Reset in the middle of RUN discards the operation.
        start_op(32'h1234, 32'd5, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_busy",      64'(bus.busy),      64'd0);
        check("mid_rst_product",   bus.product,        64'd0);
        check("mid_rst_in_ready",  64'(bus.in_ready),  64'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("mid_rel_in_ready_pre_edge", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        check("mid_rel_in_ready", 64'(bus.in_ready), 64'd1);
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        check("mid_rst_no_result", 64'(seen), 64'd0);
        do_op("post_rst_9x9", 32'd9, 32'd9, 1'b0, 64'd81, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
